dma_bus_arbiter: RTL
====================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of all address and data buses.
REQ-002 Parameter BURST_LEN, default 12, words per DMA burst (range 1..255).
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset_N  in  1  reset is asynchronous and active-low.
REQ-005 cpu_readM  in  1  CPU data-read request, held until cpu_doneM.
REQ-006 cpu_writeM  in  1  CPU data-write request, held until cpu_doneM.
REQ-007 cpu_address  in  WORD_SIZE  CPU data address.
REQ-008 cpu_wdata  in  WORD_SIZE  CPU write data.
REQ-009 cpu_rdata  out  WORD_SIZE  CPU read data, valid when cpu_doneM=1.
REQ-010 cpu_doneM  out  1  one-cycle pulse completing a CPU access.
REQ-011 cpu_stall  out  1  CPU must freeze its memory stage.
REQ-012 BR  in  1  DMA bus request.
REQ-013 BG  out  1  bus grant to DMA.
REQ-014 dma_write  in  1  1 means the DMA writes memory; 0 means it reads.
REQ-015 dma_address  in  WORD_SIZE  DMA word address, advanced by the DMA on each dma_doneM.
REQ-016 dma_wdata  in  WORD_SIZE  DMA write data.
REQ-017 dma_rdata  out  WORD_SIZE  DMA read data, valid when dma_doneM=1.
REQ-018 dma_doneM  out  1  per-word completion pulse to the DMA.
REQ-019 dma_end  out  1  one-cycle pulse (interrupt) after the last burst word.
REQ-020 m_readM / m_writeM  out  1  memory read/write strobes.
REQ-021 m_address / m_wdata  out  WORD_SIZE  memory address and write data.
REQ-022 m_rdata  in  WORD_SIZE  memory read data.
REQ-023 m_doneM  in  1  memory completion pulse; latency is at least 1 cycle.

Function
REQ-024 The block SHALL implement the FSM states IDLE, CPU, GRANT and BURST.
REQ-025 In IDLE with BR=1, the FSM SHALL go to GRANT; DMA has priority over a simultaneous CPU request.
REQ-026 In IDLE with BR=0 and a CPU request, the m_* outputs SHALL follow the cpu_* inputs in the same cycle, and the FSM SHALL go to CPU.
REQ-027 In CPU, m_* SHALL follow cpu_*; on m_doneM, cpu_doneM=1 and cpu_rdata=m_rdata in that cycle, then the FSM SHALL go to IDLE.
REQ-028 BR asserted during CPU SHALL NOT abort the access; it is serviced after m_doneM via IDLE.
REQ-029 In GRANT, BG=1, the word counter SHALL clear, and the FSM SHALL go to BURST after exactly 1 cycle with no memory strobe.
REQ-030 In BURST:
- BG=1.
- m_readM=!dma_write, m_writeM=dma_write, m_address=dma_address, m_wdata=dma_wdata.
- Each m_doneM SHALL pulse dma_doneM, drive dma_rdata=m_rdata, and increment the counter.
REQ-031 On m_doneM with counter==BURST_LEN-1, the FSM SHALL go to IDLE, BG SHALL drop next cycle, and dma_end SHALL pulse 1 cycle coincident with BG falling.
REQ-032 A BR deassertion mid-burst SHALL be ignored; the burst always completes BURST_LEN words.
REQ-033 cpu_stall SHALL equal (cpu_readM|cpu_writeM) & (state∈{GRANT,BURST} | (state==IDLE & BR)).
REQ-034 m_doneM in IDLE or GRANT SHALL be ignored.
REQ-035 The counter SHALL be ceil(log2(BURST_LEN+1)) bits wide and SHALL never wrap within a burst.
REQ-036 Outside the active state, m_readM=m_writeM=0, and all data/address outputs SHALL be 0.

Reset
REQ-037 Reset_N=0 SHALL immediately force state=IDLE, counter=0, and BG, dma_end, cpu_doneM, dma_doneM, cpu_stall, m_readM and m_writeM all to 0, including mid-burst.
REQ-038 After reset release, the first grant SHALL require a fresh BR sample in IDLE.

Structure
REQ-039 The FSM state encoding and the default WORD_SIZE and BURST_LEN SHALL live in the shared constants package.
REQ-040 The word counter with its terminal-count flag SHALL be the sub-module burst_counter.

Verification
REQ-041 CPU read at 0x0010, m_doneM after 2 cycles, m_rdata=0xBEEF -> cpu_doneM pulse with cpu_rdata=0xBEEF, BG stays 0.
REQ-042 BR and cpu_readM rise in the same IDLE cycle -> BG=1 next cycle, cpu_stall=1 for all 12 words, then the CPU access completes.
REQ-043 BR during an in-flight CPU write -> the write completes first, then GRANT, then 12 dma_doneM pulses, then dma_end=1 for 1 cycle.
REQ-044 BR drops after word 3 -> the burst still gives 12 dma_doneM pulses and one dma_end.
REQ-045 Reset_N low after word 5 -> BG=0 asynchronously; a new BR later yields a full 12-word burst.
REQ-046 BURST_LEN=1 -> exactly one dma_doneM and dma_end in the cycle after it.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared constants for the DMA/CPU memory bus arbiter: default bus
// geometry, the arbiter state encoding and the burst counter width helper.
package dma_bus_arbiter_pkg;

    // Default width of every address and data bus
    localparam int DEFAULT_WORD_SIZE = 16;

    // Default number of words moved per DMA burst
    localparam int DEFAULT_BURST_LEN = 12;

    // Arbiter states: nobody on the bus, CPU access in flight,
    // one-cycle hand-over to the DMA, DMA burst in flight
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CPU   = 2'd1,
        ST_GRANT = 2'd2,
        ST_BURST = 2'd3
    } arb_state_t;

    // Counter width able to hold 0..burst_len without wrapping
    function automatic int cnt_width(input int burst_len);
        int w;
        if (burst_len < 1) begin
            w = 1;
        end else begin
            w = $clog2(burst_len + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_burst_counter.sv
// Word counter for a DMA burst. Cleared on grant, advanced on each
// completed word, saturating at BURST_LEN so it can never wrap inside
// a burst. 'terminal' flags that the word now in flight is the last one.
module burst_counter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int CNT_W     = cnt_width(BURST_LEN)
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] count_r;

    // Count completed burst words; clear wins over increment, hold at full
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (inc && (count_r != CNT_FULL)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign terminal = (count_r == CNT_LAST);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Memory bus arbiter between a CPU data port and a burst DMA engine.
// The DMA wins ties; a CPU access already on the bus is never aborted.
// A DMA burst always completes BURST_LEN words once granted, and the
// end-of-burst interrupt pulses in the cycle the grant drops.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    // CPU data port
    input  logic                 cpu_readM,
    input  logic                 cpu_writeM,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_doneM,
    output logic                 cpu_stall,
    // DMA port
    input  logic                 BR,
    output logic                 BG,
    input  logic                 dma_write,
    input  logic [WORD_SIZE-1:0] dma_address,
    input  logic [WORD_SIZE-1:0] dma_wdata,
    output logic [WORD_SIZE-1:0] dma_rdata,
    output logic                 dma_doneM,
    output logic                 dma_end,
    // Memory port
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    input  logic                 m_doneM
);

    localparam int               CNT_W    = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
    localparam logic [WORD_SIZE-1:0] WORD_ZERO = {WORD_SIZE{1'b0}};

    arb_state_t       state_r;
    logic             dma_end_r;
    logic             cpu_req_s;
    logic             cnt_clear_s;
    logic             cnt_inc_s;
    logic [CNT_W-1:0] count_s;
    logic             terminal_s;
    logic             cnt_sat_s;
    logic             burst_last_s;

    assign cpu_req_s   = cpu_readM | cpu_writeM;
    assign cnt_clear_s = (state_r == ST_GRANT);
    assign cnt_inc_s   = (state_r == ST_BURST) & m_doneM;

    // A saturated counter in BURST can only come from corruption; leave
    // the burst rather than hold the bus forever.
    assign cnt_sat_s    = (count_s >= CNT_FULL);
    assign burst_last_s = (m_doneM & terminal_s) | cnt_sat_s;

    burst_counter #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_burst_counter (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .clear    (cnt_clear_s),
        .inc      (cnt_inc_s),
        .count    (count_s),
        .terminal (terminal_s)
    );

    // Arbiter FSM with the registered end-of-burst interrupt
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r   <= ST_IDLE;
            dma_end_r <= 1'b0;
        end else begin
            dma_end_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (BR) begin
                        state_r <= ST_GRANT;
                    end else if (cpu_req_s) begin
                        state_r <= ST_CPU;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CPU: begin
                    if (m_doneM) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CPU;
                    end
                end
                ST_GRANT: begin
                    state_r <= ST_BURST;
                end
                ST_BURST: begin
                    if (burst_last_s) begin
                        state_r   <= ST_IDLE;
                        dma_end_r <= 1'b1;
                    end else begin
                        state_r <= ST_BURST;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus steering: memory port, completions and stall decoded from state
    always_comb begin
        BG        = 1'b0;
        cpu_stall = 1'b0;
        cpu_doneM = 1'b0;
        cpu_rdata = WORD_ZERO;
        dma_doneM = 1'b0;
        dma_rdata = WORD_ZERO;
        m_readM   = 1'b0;
        m_writeM  = 1'b0;
        m_address = WORD_ZERO;
        m_wdata   = WORD_ZERO;
        if (!Reset_N) begin
            // Reset must silence the pass-through paths immediately
            BG = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (BR) begin
                        cpu_stall = cpu_req_s;
                    end else if (cpu_req_s) begin
                        m_readM   = cpu_readM;
                        m_writeM  = cpu_writeM;
                        m_address = cpu_address;
                        m_wdata   = cpu_wdata;
                    end else begin
                        cpu_stall = 1'b0;
                    end
                end
                ST_CPU: begin
                    m_readM   = cpu_readM;
                    m_writeM  = cpu_writeM;
                    m_address = cpu_address;
                    m_wdata   = cpu_wdata;
                    if (m_doneM) begin
                        cpu_doneM = 1'b1;
                        cpu_rdata = m_rdata;
                    end else begin
                        cpu_doneM = 1'b0;
                    end
                end
                ST_GRANT: begin
                    BG        = 1'b1;
                    cpu_stall = cpu_req_s;
                end
                ST_BURST: begin
                    BG        = 1'b1;
                    cpu_stall = cpu_req_s;
                    m_readM   = ~dma_write;
                    m_writeM  = dma_write;
                    m_address = dma_address;
                    m_wdata   = dma_wdata;
                    if (m_doneM) begin
                        dma_doneM = 1'b1;
                        dma_rdata = m_rdata;
                    end else begin
                        dma_doneM = 1'b0;
                    end
                end
                default: begin
                    BG = 1'b0;
                end
            endcase
        end
    end

    assign dma_end = dma_end_r;

endmodule
